// File: rtl/ysyx_exu_lsq_if.sv
// Bundle for the execute-stage load/store queue: enqueue, LSU bus, writeback.
// slave = queue side, master = upstream / LSU / writeback side.
interface ysyx_exu_lsq_if #(
  parameter int BIT_W = 32,
  parameter int DEPTH = 4,
  parameter int RD_W  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic             in_ren;
  logic             in_wen;
  logic [2:0]       in_func3;
  logic [RD_W-1:0]  in_rd;
  logic [BIT_W-1:0] in_base;
  logic [BIT_W-1:0] in_imm;
  logic [BIT_W-1:0] in_wdata;
  logic [BIT_W-1:0] in_pc;
  logic             flush;
  logic             lsu_avalid_o;
  logic [BIT_W-1:0] lsu_addr_o;
  logic [BIT_W-1:0] lsu_wdata_o;
  logic             lsu_wen_o;
  logic [2:0]       lsu_func3_o;
  logic [BIT_W-1:0] lsu_rdata;
  logic             lsu_rvalid;
  logic             lsu_wready;
  logic             out_valid;
  logic             out_ready;
  logic [RD_W-1:0]  out_rd;
  logic [BIT_W-1:0] out_rdata;
  logic [BIT_W-1:0] out_addr;
  logic [BIT_W-1:0] out_pc;
  logic [CW-1:0]    count_o;

  modport slave (
    input  in_valid, in_ren, in_wen, in_func3,
    input  in_rd, in_base, in_imm, in_wdata, in_pc,
    input  flush, lsu_rdata, lsu_rvalid, lsu_wready,
    input  out_ready,
    output in_ready, lsu_avalid_o, lsu_addr_o,
    output lsu_wdata_o, lsu_wen_o, lsu_func3_o,
    output out_valid, out_rd, out_rdata, out_addr,
    output out_pc, count_o
  );

  modport master (
    output in_valid, in_ren, in_wen, in_func3,
    output in_rd, in_base, in_imm, in_wdata, in_pc,
    output flush, lsu_rdata, lsu_rvalid, lsu_wready,
    output out_ready,
    input  in_ready, lsu_avalid_o, lsu_addr_o,
    input  lsu_wdata_o, lsu_wen_o, lsu_func3_o,
    input  out_valid, out_rd, out_rdata, out_addr,
    input  out_pc, count_o
  );
endinterface

// File: rtl/ysyx_exu_lsq.sv
// In-order load/store queue: enqueue, one-at-a-time LSU issue, in-order retire.
// Ports: clk, rst (sync, active-high), bus (ysyx_exu_lsq_if.slave).
// Macro YSYX_LSQ_FWD_EN enables word store-to-load forwarding.
module ysyx_exu_lsq #(
  parameter int BIT_W = 32,
  parameter int DEPTH = 4,
  parameter int RD_W  = 4
) (
  input logic           clk,
  input logic           rst,
  ysyx_exu_lsq_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = 1;

  typedef enum logic [1:0] {
    E_FREE, E_WAIT, E_BUSY, E_DONE
  } ent_e;
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_DRAIN
  } fsm_e;

  ent_e             r_st    [DEPTH];
  logic             r_wen   [DEPTH];
  logic [2:0]       r_f3    [DEPTH];
  logic [RD_W-1:0]  r_rd    [DEPTH];
  logic [BIT_W-1:0] r_addr  [DEPTH];
  logic [BIT_W-1:0] r_wdata [DEPTH];
  logic [BIT_W-1:0] r_pc    [DEPTH];
  logic [BIT_W-1:0] r_rdata [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_issue;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  fsm_e             r_fsm;
  logic             r_avalid;
  logic             r_bwen;
  logic [2:0]       r_bf3;
  logic [BIT_W-1:0] r_baddr;
  logic [BIT_W-1:0] r_bwdata;

  logic             w_enq;
  logic             w_deq;
  logic             w_outv;
  logic             w_done;
  logic             w_in_st;
  logic             w_hit_wait;
  logic             w_cand;
  logic             w_c_wen;
  logic [2:0]       w_c_f3;
  logic [BIT_W-1:0] w_c_addr;
  logic [BIT_W-1:0] w_c_wdata;
  logic [BIT_W-1:0] w_in_addr;
  logic             w_fwd;
  logic [BIT_W-1:0] w_fwd_data;

  function automatic logic [BIT_W-1:0] ext(
    input logic [2:0]       f,
    input logic [BIT_W-1:0] d
  );
    case (f)
      3'd0:    return {{(BIT_W-8){d[7]}}, d[7:0]};
      3'd1:    return {{(BIT_W-16){d[15]}}, d[15:0]};
      3'd4:    return {{(BIT_W-8){1'b0}}, d[7:0]};
      3'd5:    return {{(BIT_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign w_in_addr = bus.in_base + bus.in_imm;
  assign w_in_st   = bus.in_wen & ~bus.in_ren;
  assign bus.in_ready = (r_count < CW'(DEPTH)) & ~bus.flush;
  assign w_enq  = bus.in_valid & bus.in_ready;
  assign w_outv = r_st[r_head] == E_DONE;
  assign w_deq  = w_outv & bus.out_ready & ~bus.flush;
  assign w_done = r_bwen ? bus.lsu_wready : bus.lsu_rvalid;

  // An op written into an empty issue slot is issued straight from the
  // enqueue inputs, so the request appears the cycle after enqueue.
  assign w_hit_wait = r_st[r_issue] == E_WAIT;
  assign w_cand = w_hit_wait
                | (w_enq & (r_tail == r_issue)
                   & (r_st[r_issue] == E_FREE));
  assign w_c_wen   = w_hit_wait ? r_wen[r_issue]   : w_in_st;
  assign w_c_f3    = w_hit_wait ? r_f3[r_issue]    : bus.in_func3;
  assign w_c_addr  = w_hit_wait ? r_addr[r_issue]  : w_in_addr;
  assign w_c_wdata = w_hit_wait ? r_wdata[r_issue] : bus.in_wdata;

`ifdef YSYX_LSQ_FWD_EN
  logic [PW-1:0] w_k;
  logic [PW-1:0] w_older;

  // Scan older entries oldest to youngest; the youngest store touching
  // the same word decides. Only an exact word-to-word match forwards.
  always_comb begin
    w_fwd      = 1'b0;
    w_fwd_data = '0;
    w_k        = '0;
    w_older    = r_issue - r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_k = r_head + PW'(i);
      if ((PW'(i) < w_older) && (r_st[w_k] != E_FREE)
          && r_wen[w_k]
          && (r_addr[w_k][BIT_W-1:2] == w_c_addr[BIT_W-1:2])) begin
        w_fwd      = (r_f3[w_k] == 3'd2)
                   && (r_addr[w_k] == w_c_addr);
        w_fwd_data = r_wdata[w_k];
      end
    end
    w_fwd = w_fwd & ~w_c_wen & (w_c_f3 == 3'd2);
  end
`else
  assign w_fwd      = 1'b0;
  assign w_fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= E_FREE;
      r_head   <= '0;
      r_issue  <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_fsm    <= S_IDLE;
      r_avalid <= 1'b0;
      r_bwen   <= 1'b0;
      r_bf3    <= '0;
      r_baddr  <= '0;
      r_bwdata <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= E_FREE;
      r_head  <= '0;
      r_issue <= '0;
      r_tail  <= '0;
      r_count <= '0;
      // The in-flight bus access must still be seen to completion.
      if (r_fsm != S_IDLE) begin
        if (w_done) begin
          r_fsm    <= S_IDLE;
          r_avalid <= 1'b0;
        end else begin
          r_fsm <= S_DRAIN;
        end
      end
    end else begin
      if (w_enq) begin
        r_st[r_tail]    <= E_WAIT;
        r_wen[r_tail]   <= w_in_st;
        r_f3[r_tail]    <= bus.in_func3;
        r_rd[r_tail]    <= bus.in_rd;
        r_addr[r_tail]  <= w_in_addr;
        r_wdata[r_tail] <= bus.in_wdata;
        r_pc[r_tail]    <= bus.in_pc;
        r_tail          <= r_tail + P_ONE;
      end
      if (w_deq) begin
        r_st[r_head] <= E_FREE;
        r_head       <= r_head + P_ONE;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      case (r_fsm)
        S_IDLE: begin
          if (w_cand && w_fwd) begin
            r_st[r_issue]    <= E_DONE;
            r_rdata[r_issue] <= w_fwd_data;
            r_issue          <= r_issue + P_ONE;
          end else if (w_cand) begin
            r_st[r_issue] <= E_BUSY;
            r_fsm    <= S_REQ;
            r_avalid <= 1'b1;
            r_bwen   <= w_c_wen;
            r_bf3    <= w_c_f3;
            r_baddr  <= w_c_addr;
            r_bwdata <= w_c_wdata;
          end
        end
        S_REQ: begin
          if (w_done) begin
            r_st[r_issue]    <= E_DONE;
            r_rdata[r_issue] <= r_bwen ? '0
                              : ext(r_bf3, bus.lsu_rdata);
            r_issue  <= r_issue + P_ONE;
            r_fsm    <= S_IDLE;
            r_avalid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_done) begin
            r_fsm    <= S_IDLE;
            r_avalid <= 1'b0;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.lsu_avalid_o = r_avalid;
  assign bus.lsu_addr_o   = r_baddr;
  assign bus.lsu_wdata_o  = r_bwdata;
  assign bus.lsu_wen_o    = r_bwen;
  assign bus.lsu_func3_o  = r_bf3;
  assign bus.out_valid = w_outv;
  assign bus.out_rd    = (w_outv & ~r_wen[r_head])
                       ? r_rd[r_head] : '0;
  assign bus.out_rdata = (w_outv & ~r_wen[r_head])
                       ? r_rdata[r_head] : '0;
  assign bus.out_addr  = w_outv ? r_addr[r_head] : '0;
  assign bus.out_pc    = w_outv ? r_pc[r_head] : '0;
  assign bus.count_o   = r_count;
endmodule
